// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 encodings and the bridge FSM state type
package axi4_pkg;
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;
  localparam logic [2:0] SIZE_64B = 3'd3;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR,
    S_WR_RESP
  } state_e;
endpackage

// File: rtl/axi4_rsp_buf.sv
// axi4_rsp_buf: one-entry valid/ready buffer for {data, last, err}, load and drain allowed together
module axi4_rsp_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         in_err,
  input  logic         rsp_ready,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_data,
  output logic         rsp_last,
  output logic         rsp_err,
  output logic         can_load
);
  assign can_load = !rsp_valid || rsp_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= in_data;
      rsp_last  <= in_last;
      rsp_err   <= in_err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
endmodule

// File: rtl/axi4_master_bridge.sv
// axi4_master_bridge: simple request port to AXI4 master, INCR burst reads and single-beat writes
module axi4_master_bridge
  import axi4_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        i_aclk,
  input  logic        i_areset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wr,
  input  logic [7:0]  i_req_addr,
  input  logic [7:0]  i_req_len,
  input  logic [63:0] i_req_wdata,
  input  logic [7:0]  i_req_wstrb,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [63:0] o_rsp_data,
  output logic        o_rsp_last,
  output logic        o_rsp_err,
  output logic [3:0]  o_arid,
  output logic [7:0]  o_araddr,
  output logic [7:0]  o_arlen,
  output logic [2:0]  o_arsize,
  output logic [1:0]  o_arburst,
  output logic        o_arlock,
  output logic [3:0]  o_arcache,
  output logic [2:0]  o_arprot,
  output logic [3:0]  o_arqos,
  output logic [3:0]  o_arregion,
  output logic        o_aruser,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [3:0]  i_rid,
  input  logic [63:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rlast,
  input  logic        i_ruser,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [3:0]  o_awid,
  output logic [7:0]  o_awaddr,
  output logic [7:0]  o_awlen,
  output logic [2:0]  o_awsize,
  output logic [1:0]  o_awburst,
  output logic        o_awlock,
  output logic [3:0]  o_awcache,
  output logic [2:0]  o_awprot,
  output logic [3:0]  o_awqos,
  output logic [3:0]  o_awregion,
  output logic        o_awuser,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [3:0]  o_wid,
  output logic [63:0] o_wdata,
  output logic [7:0]  o_wstrb,
  output logic        o_wlast,
  output logic        o_wuser,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic [3:0]  i_bid,
  input  logic [1:0]  i_bresp,
  input  logic        i_buser,
  input  logic        i_bvalid,
  output logic        o_bready
);
  state_e      state, state_nx;
  logic [7:0]  addr_q, len_q, cnt_q, wstrb_q;
  logic [63:0] wdata_q;
  logic        aw_done, w_done, aw_nx, w_nx;
  logic        req_hs, r_hs, b_hs, can_load, ld_err;
  logic        unused;
  assign unused = ^{i_rid, i_bid, i_ruser, i_buser};
  assign o_arid     = AXI_ID;
  assign o_awid     = AXI_ID;
  assign o_wid      = AXI_ID;
  assign o_arsize   = SIZE_64B;
  assign o_awsize   = SIZE_64B;
  assign o_arburst  = BURST_INCR;
  assign o_awburst  = BURST_INCR;
  assign o_awlen    = 8'd0;
  assign o_arlock   = 1'b0;
  assign o_arcache  = 4'd0;
  assign o_arprot   = 3'd0;
  assign o_arqos    = 4'd0;
  assign o_arregion = 4'd0;
  assign o_aruser   = 1'b0;
  assign o_awlock   = 1'b0;
  assign o_awcache  = 4'd0;
  assign o_awprot   = 3'd0;
  assign o_awqos    = 4'd0;
  assign o_awregion = 4'd0;
  assign o_awuser   = 1'b0;
  assign o_wuser    = 1'b0;
  assign o_wlast    = 1'b1;
  assign o_araddr   = addr_q;
  assign o_awaddr   = addr_q;
  assign o_arlen    = len_q;
  assign o_wdata    = wdata_q;
  assign o_wstrb    = wstrb_q;
  // req_ready is gated by reset so every ready reads low while reset is held
  assign o_req_ready = i_areset_n && state == S_IDLE && !o_rsp_valid;
  assign o_arvalid   = state == S_RD_ADDR;
  assign o_rready    = state == S_RD_DATA && can_load;
  assign o_awvalid   = state == S_WR && !aw_done;
  assign o_wvalid    = state == S_WR && !w_done;
  assign o_bready    = state == S_WR_RESP && !o_rsp_valid;
  assign req_hs = i_req_valid && o_req_ready;
  assign r_hs   = i_rvalid && o_rready;
  assign b_hs   = i_bvalid && o_bready;
  assign aw_nx  = aw_done || (o_awvalid && i_awready);
  assign w_nx   = w_done || (o_wvalid && i_wready);
  // a beat is flagged when the slave's rlast disagrees with the requested length
  assign ld_err = r_hs ? (i_rresp != RESP_OKAY || i_rlast != (cnt_q == len_q)) : (i_bresp != RESP_OKAY);
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    state_nx = req_hs ? (i_req_wr ? S_WR : S_RD_ADDR) : S_IDLE;
      S_RD_ADDR: state_nx = i_arready ? S_RD_DATA : S_RD_ADDR;
      S_RD_DATA: state_nx = (r_hs && i_rlast) ? S_IDLE : S_RD_DATA;
      S_WR:      state_nx = (aw_nx && w_nx) ? S_WR_RESP : S_WR;
      S_WR_RESP: state_nx = b_hs ? S_IDLE : S_WR_RESP;
      default:   state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge i_aclk or negedge i_areset_n)
    if (!i_areset_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nx;
      if (req_hs) begin
        addr_q  <= i_req_addr;
        len_q   <= i_req_len;
        wdata_q <= i_req_wdata;
        wstrb_q <= i_req_wstrb;
      end
      cnt_q   <= req_hs ? 8'd0 : r_hs ? cnt_q + 8'd1 : cnt_q;
      aw_done <= state_nx == S_WR && aw_nx;
      w_done  <= state_nx == S_WR && w_nx;
    end
  axi4_rsp_buf #(.W(64)) u_rsp_buf (
    .clk       (i_aclk),
    .rst_n     (i_areset_n),
    .load      (r_hs || b_hs),
    .in_data   (r_hs ? i_rdata : 64'd0),
    .in_last   (r_hs ? i_rlast : 1'b1),
    .in_err    (ld_err),
    .rsp_ready (i_rsp_ready),
    .rsp_valid (o_rsp_valid),
    .rsp_data  (o_rsp_data),
    .rsp_last  (o_rsp_last),
    .rsp_err   (o_rsp_err),
    .can_load  (can_load)
  );
endmodule

// File: tb/tb_axi4_master_bridge.sv
// tb_axi4_master_bridge: scoreboard bench with a behavioural SRAM slave for axi4_master_bridge
module tb_axi4_master_bridge;
  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        err;
  } rsp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        areset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_wr = 1'b0;
  logic [7:0]  req_addr = 8'd0, req_len = 8'd0, req_wstrb = 8'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_last, rsp_err;
  logic [63:0] rsp_data;
  logic [3:0]  arid, awid, wid, arcache, arqos, arregion, awcache, awqos, awregion;
  logic [7:0]  araddr, arlen, awaddr, awlen, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arlock, aruser, awlock, awuser, wuser;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [63:0] rdata, wdata;
  int checks = 0, failures = 0, rsp_seen = 0, bp_mode = 0;
  logic [2:0]  aw_delay = 3'd0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic        rlast_early = 1'b0;
  rsp_t        exp_q[$];
  logic [63:0] ref_mem [0:31];

  axi4_master_bridge #(.AXI_ID(4'd5)) dut (
    .i_aclk(clk), .i_areset_n(areset_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr(req_wr),
    .i_req_addr(req_addr), .i_req_len(req_len), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_rsp_last(rsp_last), .o_rsp_err(rsp_err),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst),
    .o_arlock(arlock), .o_arcache(arcache), .o_arprot(arprot), .o_arqos(arqos),
    .o_arregion(arregion), .o_aruser(aruser), .o_arvalid(arvalid), .i_arready(arready),
    .i_rid(4'd5), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_ruser(1'b0),
    .i_rvalid(rvalid), .o_rready(rready),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize), .o_awburst(awburst),
    .o_awlock(awlock), .o_awcache(awcache), .o_awprot(awprot), .o_awqos(awqos),
    .o_awregion(awregion), .o_awuser(awuser), .o_awvalid(awvalid), .i_awready(awready),
    .o_wid(wid), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wuser(wuser),
    .o_wvalid(wvalid), .i_wready(wready),
    .i_bid(4'd5), .i_bresp(bresp), .i_buser(1'b0), .i_bvalid(bvalid), .o_bready(bready)
  );

  function automatic logic [63:0] init_word(input int i);
    return i == 2 ? 64'h1122334455667788 : {32'hCAFE0000 + 32'(i), 32'h12340000 + 32'(i)};
  endfunction

  // behavioural SRAM slave
  logic [63:0] mem [0:31];
  logic        rd_act, aw_got, w_got, bvalid_q;
  logic [4:0]  rd_ptr, aw_ptr;
  logic [8:0]  rd_left;
  logic [2:0]  aw_wait;
  logic [63:0] wbuf;
  logic [7:0]  sbuf;
  assign arready = 1'b1;
  assign rvalid  = rd_act;
  assign rdata   = mem[rd_ptr];
  assign rresp   = 2'b00;
  assign rlast   = rd_left == (rlast_early ? 9'd2 : 9'd1);
  assign awready = awvalid && aw_wait == 3'd0;
  assign wready  = 1'b1;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_cfg;
  always @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      rd_act <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; bvalid_q <= 1'b0;
      rd_ptr <= '0; rd_left <= '0; aw_wait <= '0; aw_ptr <= '0; wbuf <= '0; sbuf <= '0;
    end else begin
      if (arvalid && arready) begin
        rd_act <= 1'b1; rd_ptr <= araddr[7:3]; rd_left <= {1'b0, arlen} + 9'd1;
      end else if (rvalid && rready) begin
        rd_ptr <= rd_ptr + 5'd1; rd_left <= rd_left - 9'd1;
        if (rlast) rd_act <= 1'b0;
      end
      aw_wait <= !awvalid ? aw_delay : (aw_wait != 3'd0 ? aw_wait - 3'd1 : aw_wait);
      if (awvalid && awready) begin aw_got <= 1'b1; aw_ptr <= awaddr[7:3]; end
      if (wvalid && wready) begin w_got <= 1'b1; wbuf <= wdata; sbuf <= wstrb; end
      if (aw_got && w_got) begin
        for (int b = 0; b < 8; b++) if (sbuf[b]) mem[aw_ptr][8*b+:8] <= wbuf[8*b+:8];
        aw_got <= 1'b0; w_got <= 1'b0; bvalid_q <= 1'b1;
      end else if (bvalid_q && bready) bvalid_q <= 1'b0;
    end

  always @(posedge clk) begin
    #1;
    rsp_ready = bp_mode == 1 ? ~rsp_ready : bp_mode == 0;
  end

  // scoreboard: every accepted response is matched against the oldest expectation
  always @(negedge clk)
    if (areset_n && rsp_valid && rsp_ready) begin
      rsp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got data=%h last=%b err=%b, none required", rsp_data, rsp_last, rsp_err);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_data, rsp_last, rsp_err} !== e) begin
          failures++;
          $display("FAIL rsp_beat got data=%h last=%b err=%b required data=%h last=%b err=%b",
                   rsp_data, rsp_last, rsp_err, e.data, e.last, e.err);
        end
      end
      rsp_seen++;
    end

  task automatic ref_init();
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic exp_read(input logic [7:0] addr, input logic [7:0] len);
    rsp_t e;
    logic [4:0] idx;
    for (int i = 0; i <= int'(len); i++) begin
      idx = addr[7:3] + 5'(i);
      e = {ref_mem[idx], i == int'(len), 1'b0};
      exp_q.push_back(e);
    end
  endtask

  task automatic exp_write(input logic [7:0] addr, input logic [63:0] wd, input logic [7:0] ws, input logic err);
    rsp_t e;
    for (int b = 0; b < 8; b++) if (ws[b]) ref_mem[addr[7:3]][8*b+:8] = wd[8*b+:8];
    e = {64'd0, 1'b1, err};
    exp_q.push_back(e);
  endtask

  task automatic do_req(input logic wr, input logic [7:0] addr, input logic [7:0] len,
                        input logic [63:0] wd, input logic [7:0] ws);
    int n = 0;
    @(negedge clk);
    req_wr = wr; req_addr = addr; req_len = len; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL req_timeout req_ready=%b required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0 || !req_ready) begin
      failures++;
      $display("FAIL %s_drain pending=%0d req_ready=%b required 0 and 1", tag, exp_q.size(), req_ready);
    end
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, rsp_valid, req_ready} !== 7'd0) begin
      failures++;
      $display("FAIL reset_handshakes got %b required 0000000", {arvalid, rready, awvalid, wvalid, bready, rsp_valid, req_ready});
    end
    checks++;
    if ({rsp_data, rsp_last, rsp_err} !== 66'd0) begin
      failures++;
      $display("FAIL reset_rsp got data=%h last=%b err=%b required 0", rsp_data, rsp_last, rsp_err);
    end
    checks++;
    if ({arsize, awsize, arburst, awburst, awlen, arid, awid, wid, wlast} !== {3'd3, 3'd3, 2'b01, 2'b01, 8'd0, 4'd5, 4'd5, 4'd5, 1'b1}) begin
      failures++;
      $display("FAIL const_attrs got size=%0d/%0d burst=%0d/%0d awlen=%0d id=%0d/%0d/%0d wlast=%b required 3/3 1/1 0 5/5/5 1",
               arsize, awsize, arburst, awburst, awlen, arid, awid, wid, wlast);
    end
    checks++;
    if ({arlock, arcache, arprot, arqos, arregion, aruser, awlock, awcache, awprot, awqos, awregion, awuser, wuser} !== 33'd0) begin
      failures++;
      $display("FAIL const_zero got %h required 0", {arlock, arcache, arprot, arqos, arregion, aruser, awlock, awcache, awprot, awqos, awregion, awuser, wuser});
    end
    areset_n = 1'b1;
    ref_init();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready got %b required 1", req_ready);
    end
  endtask

  task automatic test_read_single();
    exp_read(8'h10, 8'd0);
    do_req(1'b0, 8'h10, 8'd0, 64'd0, 8'd0);
    checks++;
    if ({arvalid, araddr, arlen} !== {1'b1, 8'h10, 8'd0}) begin
      failures++;
      $display("FAIL ar_issue got arvalid=%b addr=%h len=%0d required 1 10 0", arvalid, araddr, arlen);
    end
    wait_drain("read_single");
  endtask

  task automatic test_burst_bp();
    int start = rsp_seen;
    bp_mode = 1;
    exp_read(8'h00, 8'd3);
    do_req(1'b0, 8'h00, 8'd3, 64'd0, 8'd0);
    wait_drain("burst_bp");
    bp_mode = 0;
    checks++;
    if (rsp_seen - start != 4) begin
      failures++;
      $display("FAIL burst_count got %0d required 4", rsp_seen - start);
    end
  endtask

  task automatic test_write_readback();
    exp_write(8'h20, 64'hDEADBEEF00000001, 8'hFF, 1'b0);
    do_req(1'b1, 8'h20, 8'd0, 64'hDEADBEEF00000001, 8'hFF);
    checks++;
    if ({awvalid, wvalid, wlast, awaddr, wdata, wstrb} !== {3'b111, 8'h20, 64'hDEADBEEF00000001, 8'hFF}) begin
      failures++;
      $display("FAIL aw_w_issue got aw=%b w=%b last=%b addr=%h data=%h strb=%h required 1 1 1 20 deadbeef00000001 ff",
               awvalid, wvalid, wlast, awaddr, wdata, wstrb);
    end
    wait_drain("write");
    exp_read(8'h20, 8'd0);
    do_req(1'b0, 8'h20, 8'd0, 64'd0, 8'd0);
    wait_drain("readback");
    exp_write(8'h28, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b0);
    do_req(1'b1, 8'h28, 8'd0, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    wait_drain("write_strb");
    exp_read(8'h20, 8'd1);
    do_req(1'b0, 8'h20, 8'd1, 64'd0, 8'd0);
    wait_drain("readback_strb");
  endtask

  task automatic test_aw_w_skew();
    int start = rsp_seen;
    aw_delay = 3'd3;
    exp_write(8'h30, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
    do_req(1'b1, 8'h30, 8'd0, 64'h0123456789ABCDEF, 8'hFF);
    checks++;
    if ({awvalid, wvalid} !== 2'b11) begin
      failures++;
      $display("FAIL skew_start got aw=%b w=%b required 1 1", awvalid, wvalid);
    end
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({awvalid, wvalid, awaddr} !== {2'b10, 8'h30}) begin
        failures++;
        $display("FAIL skew_cycle%0d got aw=%b w=%b addr=%h required 1 0 30", c, awvalid, wvalid, awaddr);
      end
    end
    wait_drain("skew");
    aw_delay = 3'd0;
    checks++;
    if (rsp_seen - start != 1) begin
      failures++;
      $display("FAIL skew_bcount got %0d required 1", rsp_seen - start);
    end
  endtask

  task automatic test_err();
    bresp_cfg = 2'b10;
    exp_write(8'h38, 64'h5555AAAA5555AAAA, 8'hFF, 1'b1);
    do_req(1'b1, 8'h38, 8'd0, 64'h5555AAAA5555AAAA, 8'hFF);
    wait_drain("bresp_err");
    bresp_cfg = 2'b00;
    exp_read(8'h30, 8'd1);
    do_req(1'b0, 8'h30, 8'd1, 64'd0, 8'd0);
    wait_drain("after_err");
  endtask

  task automatic test_rlast_early();
    rsp_t e;
    rlast_early = 1'b1;
    e = {ref_mem[0], 1'b0, 1'b0}; exp_q.push_back(e);
    e = {ref_mem[1], 1'b0, 1'b0}; exp_q.push_back(e);
    e = {ref_mem[2], 1'b1, 1'b1}; exp_q.push_back(e);
    do_req(1'b0, 8'h00, 8'd3, 64'd0, 8'd0);
    wait_drain("rlast_early");
    rlast_early = 1'b0;
  endtask

  task automatic test_reset_mid();
    int start = rsp_seen;
    int n = 0;
    exp_read(8'h00, 8'd7);
    do_req(1'b0, 8'h00, 8'd7, 64'd0, 8'd0);
    while (rsp_seen - start < 2 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    areset_n = 1'b0;
    #1;
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, rsp_valid, req_ready} !== 7'd0) begin
      failures++;
      $display("FAIL midreset_handshakes got %b required 0000000", {arvalid, rready, awvalid, wvalid, bready, rsp_valid, req_ready});
    end
    exp_q.delete();
    ref_init();
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_req_ready got %b required 1", req_ready);
    end
    exp_read(8'h10, 8'd1);
    do_req(1'b0, 8'h10, 8'd1, 64'd0, 8'd0);
    wait_drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_read_single();
    test_burst_bp();
    test_write_readback();
    test_aw_w_skew();
    test_err();
    test_rlast_early();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
